seven_seg_capture: RTL and testbench

- Receive-side counterpart of the multiplexed 4-digit seven-segment driver.
- Samples the segment lines A..G and digit selects CS1..CS4 of a scanned display, debounces each digit dwell and decodes each segment pattern back to BCD.
- Assembles one complete frame of four digits and emits the displayed number as a 14-bit binary value.
- Used as a loopback monitor and self-check on driver outputs, and for reading external displays.

---
 rtl/seven_seg_capture.sv | 193 +++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: receive side of a scanned 4-digit seven-segment display.
// Synchronises segment and digit-select lines, debounces each digit dwell,
// decodes the pattern to BCD, and emits each complete frame as a binary number.
// Optional watchdog: define SEVSEG_STALE_EN to build the stale-frame detector.
module seven_seg_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          CS_ACTIVE_LOW  = 1'b0,
    parameter int unsigned STALE_CYCLES   = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    input  logic        D,
    input  logic        E,
    input  logic        F,
    input  logic        G,
    input  logic        CS1,
    input  logic        CS2,
    input  logic        CS3,
    input  logic        CS4,
    output logic [13:0] value,
    output logic        valid,
    output logic        err,
    output logic        stale
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [10:0] raw, sync1, sync2, prev_sample;
    logic [6:0]  seg;
    logic [3:0]  cs;
    logic [7:0]  stable_cnt;
    logic        same, onehot, capture;
    logic [3:0]  dec_digit;
    logic        dec_bad;
    logic [1:0]  slot;
    logic [3:0]  digit [4];
    logic [3:0]  snap  [4];
    logic [3:0]  flags, bad;
    logic        frame_full, emit_good, emit_bad;
    logic [13:0] weighted;

    assign raw = {A, B, C, D, E, F, G, CS4, CS3, CS2, CS1};

    // Two-flop synchroniser on all eleven display lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign seg    = sync2[10:4] ^ {7{SEG_ACTIVE_LOW}};
    assign cs     = sync2[3:0]  ^ {4{CS_ACTIVE_LOW}};
    assign same   = ({cs, seg} == prev_sample);
    assign onehot = (cs != '0) && ((cs & (cs - 4'd1)) == '0);
    // Saturation at STABLE_MAX makes this fire once per stable dwell
    assign capture = same && onehot && (stable_cnt == STABLE_MAX - 8'd1);

    // Stability counter: run while the one-hot sample holds, restart otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sample <= '0;
            stable_cnt  <= '0;
        end else begin
            prev_sample <= {cs, seg};
            if (same && onehot) begin
                if (stable_cnt != STABLE_MAX)
                    stable_cnt <= stable_cnt + 8'd1;
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    // Segment pattern (a..g) to BCD, including common alternate glyphs
    always_comb begin
        dec_digit = 4'd0;
        dec_bad   = 1'b0;
        case (seg)
            7'b1111110, 7'b0000000:             dec_digit = 4'd0;
            7'b0110000:                         dec_digit = 4'd1;
            7'b1101101:                         dec_digit = 4'd2;
            7'b1111001:                         dec_digit = 4'd3;
            7'b0110011:                         dec_digit = 4'd4;
            7'b1011011:                         dec_digit = 4'd5;
            7'b1011111, 7'b0011111:             dec_digit = 4'd6;
            7'b1110000, 7'b1110010:             dec_digit = 4'd7;
            7'b1111111:                         dec_digit = 4'd8;
            7'b1111011, 7'b1110011:             dec_digit = 4'd9;
            default:                            dec_bad   = 1'b1;
        endcase
    end

    // Digit position from the one-hot select
    always_comb begin
        slot = 2'd0;
        case (cs)
            4'b0010: slot = 2'd1;
            4'b0100: slot = 2'd2;
            4'b1000: slot = 2'd3;
            default: slot = 2'd0;
        endcase
    end

    assign frame_full = &flags;

    // Frame store; a capture in the emit cycle lands in the freshly cleared frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
            bad   <= '0;
            for (int unsigned i = 0; i < 4; i++) digit[i] <= '0;
        end else begin
            if (frame_full) begin
                flags <= '0;
                bad   <= '0;
            end
            if (capture) begin
                digit[slot] <= dec_digit;
                flags[slot] <= 1'b1;
                bad[slot]   <= dec_bad;
            end
        end
    end

    // Emission stage: snapshot the completed frame and classify it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            emit_good <= 1'b0;
            emit_bad  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) snap[i] <= '0;
        end else begin
            emit_good <= frame_full && !(|bad);
            emit_bad  <= frame_full && (|bad);
            if (frame_full)
                for (int unsigned i = 0; i < 4; i++) snap[i] <= digit[i];
        end
    end

    // BCD frame to binary
    always_comb begin
        weighted = 14'(snap[3]) * 14'd1000 + 14'(snap[2]) * 14'd100
                 + 14'(snap[1]) * 14'd10   + 14'(snap[0]);
    end

    // Output stage: value updates only on good frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= emit_good;
            err   <= emit_bad;
            if (emit_good)
                value <= weighted;
        end
    end

`ifdef SEVSEG_STALE_EN
    localparam int unsigned         STALE_W   = $clog2(STALE_CYCLES + 1);
    localparam logic [STALE_W-1:0]  STALE_MAX = STALE_W'(STALE_CYCLES);

    logic [STALE_W-1:0] stale_cnt;

    // Watchdog: count since last valid; stale latches at the period, clears after valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else if (valid) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else begin
            if (stale_cnt != STALE_MAX)
                stale_cnt <= stale_cnt + 1'b1;
            if (stale_cnt == STALE_MAX - 1'b1)
                stale <= 1'b1;
        end
    end
`else
    // Watchdog not built; the period stays referenced so both builds share one parameter list
    assign stale = (STALE_CYCLES == 0) & 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed vectors for seven_seg_capture (default build).
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        A, B, C, D, E, F, G;
    logic        CS1, CS2, CS3, CS4;
    logic [13:0] value;
    logic        valid, err, stale;

    int vectors     = 0;
    int miscompares = 0;
    int vcnt        = 0;
    int ecnt        = 0;
    int both_cnt    = 0;

    seven_seg_capture #(
        .STABLE_CYCLES (4),
        .SEG_ACTIVE_LOW(1'b0),
        .CS_ACTIVE_LOW (1'b0),
        .STALE_CYCLES  (200)
    ) dut (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
        .CS1(CS1), .CS2(CS2), .CS3(CS3), .CS4(CS4),
        .value(value), .valid(valid), .err(err), .stale(stale)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping, sampled on the inactive edge
    always @(negedge clk) begin
        if (valid) vcnt++;
        if (err) ecnt++;
        if (valid && err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Digit 10 = blank, 11 = illegal glyph
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;   1: return 7'b0110000;
            2: return 7'b1101101;   3: return 7'b1111001;
            4: return 7'b0110011;   5: return 7'b1011011;
            6: return 7'b1011111;   7: return 7'b1110000;
            8: return 7'b1111111;   9: return 7'b1111011;
            10: return 7'b0000000;
            default: return 7'b1000001;
        endcase
    endfunction

    task automatic drive(input logic [3:0] cs, input logic [6:0] seg);
        {A, B, C, D, E, F, G} = seg;
        {CS4, CS3, CS2, CS1}  = cs;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dig(input logic [3:0] cs, input int d, input int n);
        drive(cs, seg_of(d));
        idle(n);
    endtask

    // Scan ones..thousands, 10 clk each, then blank selects
    task automatic frame(input int d4, input int d3, input int d2, input int d1);
        dig(4'b0001, d1, 10);
        dig(4'b0010, d2, 10);
        dig(4'b0100, d3, 10);
        dig(4'b1000, d4, 10);
        drive(4'b0000, 7'b0000000);
        idle(10);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        drive(4'b0000, 7'b0000000);
        idle(3);
        check("rst_value", 32'(value), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_err",   32'(err),   0);
        check("rst_stale", 32'(stale), 0);
        rst = 1'b0;
        idle(3);

        // 1234 with completion latency measured from the last digit drive
        dig(4'b0001, 4, 10);
        dig(4'b0010, 3, 10);
        dig(4'b0100, 2, 10);
        drive(4'b1000, seg_of(1));
        lat = 0;
        while (!valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency_1234", 32'(lat), 9);
        idle(5);
        drive(4'b0000, 7'b0000000);
        idle(10);
        check("value_1234", 32'(value), 1234);
        check("vcnt_1234",  32'(vcnt),  1);
        check("ecnt_1234",  32'(ecnt),  0);

        frame(9, 9, 9, 9);
        check("value_9999", 32'(value), 9999);
        check("vcnt_9999",  32'(vcnt),  2);

        frame(10, 10, 10, 0);
        check("value_blank0", 32'(value), 0);
        check("vcnt_blank0",  32'(vcnt),  3);

        // Reverse scan order
        dig(4'b1000, 1, 10);
        dig(4'b0100, 2, 10);
        dig(4'b0010, 3, 10);
        dig(4'b0001, 4, 10);
        drive(4'b0000, 7'b0000000);
        idle(10);
        check("value_rev1234", 32'(value), 1234);
        check("vcnt_rev1234",  32'(vcnt),  4);

        // Illegal glyph on the tens digit of 5678
        frame(5, 6, 11, 8);
        check("ecnt_bad",  32'(ecnt),  1);
        check("vcnt_bad",  32'(vcnt),  4);
        check("value_bad", 32'(value), 1234);
        frame(5, 6, 7, 8);
        check("value_5678", 32'(value), 5678);
        check("vcnt_5678",  32'(vcnt),  5);
        check("ecnt_5678",  32'(ecnt),  1);

        // 0042 with a 3-clk glyph glitch and a 2-clk CS1/CS2 overlap
        dig(4'b0001, 2, 10);
        dig(4'b0001, 8, 3);
        dig(4'b0011, 4, 2);
        dig(4'b0010, 4, 10);
        dig(4'b0100, 10, 10);
        dig(4'b1000, 10, 10);
        drive(4'b0000, 7'b0000000);
        idle(10);
        check("value_0042", 32'(value), 42);
        check("vcnt_0042",  32'(vcnt),  6);
        check("ecnt_0042",  32'(ecnt),  1);

        // Reset after two digits of 8765; leftover half frame must not complete
        dig(4'b0001, 5, 10);
        dig(4'b0010, 6, 10);
        drive(4'b0000, 7'b0000000);
        rst = 1'b1;
        idle(2);
        check("midrst_value", 32'(value), 0);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_err",   32'(err),   0);
        rst = 1'b0;
        idle(3);
        dig(4'b0100, 7, 10);
        dig(4'b1000, 8, 10);
        drive(4'b0000, 7'b0000000);
        idle(10);
        check("partial_vcnt",  32'(vcnt),  6);
        check("partial_value", 32'(value), 0);
        frame(8, 7, 6, 5);
        check("value_8765", 32'(value), 8765);
        check("vcnt_8765",  32'(vcnt),  7);
        check("ecnt_final", 32'(ecnt),  1);
        check("valid_err_overlap", 32'(both_cnt), 0);
        check("stale_tied", 32'(stale), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
